// File: rtl/leg_alu_reg.sv
// LEG execute-stage ALU: logic/add/shift on 64-bit operands with NZCV flags,
// result and flags registered with one cycle of latency.
module leg_alu_reg #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] Ain,
    input  logic [DATA_W-1:0] Bin,
    input  logic [4:0]        ALUCtl,
    input  logic              carryIn,
    output logic [DATA_W-1:0] ALUOut,
    output logic [3:0]        status
);

    localparam int unsigned SUM_W = DATA_W + 1;
    localparam int unsigned MSB   = DATA_W - 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_LSL = 3'b100;
    localparam logic [2:0] OP_LSR = 3'b101;

    logic [DATA_W-1:0]  a2;
    logic [DATA_W-1:0]  b2;
    logic [SUM_W-1:0]   sum;
    logic [SHAMT_W-1:0] shamt;
    logic [2:0]         op;
    logic [DATA_W-1:0]  f;
    logic               flag_c;
    logic               flag_v;
    logic [3:0]         flags;

    // Operand conditioning and the full-width adder shared by add/sub.
    always_comb begin
        op    = ALUCtl[4:2];
        a2    = ALUCtl[1] ? ~Ain : Ain;
        b2    = ALUCtl[0] ? ~Bin : Bin;
        sum   = SUM_W'(a2) + SUM_W'(b2) + SUM_W'(carryIn);
        shamt = Bin[SHAMT_W-1:0];
    end

    // Function select; C and V are only meaningful for the adder.
    always_comb begin
        f      = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        unique case (op)
            OP_AND: f = a2 & b2;
            OP_OR:  f = a2 | b2;
            OP_ADD: begin
                f      = sum[DATA_W-1:0];
                flag_c = sum[DATA_W];
                flag_v = (a2[MSB] == b2[MSB]) && (sum[MSB] != a2[MSB]);
            end
            OP_XOR: f = a2 ^ b2;
            OP_LSL: f = Ain << shamt;
            OP_LSR: f = Ain >> shamt;
            default: f = '0;
        endcase
        flags = {flag_v, flag_c, f[MSB], (f == '0)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ALUOut <= '0;
            status <= 4'b0000;
        end else begin
            ALUOut <= f;
            status <= flags;
        end
    end

endmodule

// File: tb/tb_leg_alu_reg.sv
// Directed-vector bench for leg_alu_reg: table of single-cycle operations plus
// a streaming sequence checking one-cycle latency and mid-stream reset.
module tb_leg_alu_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] Ain;
    logic [63:0] Bin;
    logic [4:0]  ALUCtl;
    logic        carryIn;
    logic [63:0] ALUOut;
    logic [3:0]  status;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [4:0]  ctl;
        logic        cin;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_out;
        logic [3:0]  exp_st;
    } vec_t;

    vec_t vecs[$];

    leg_alu_reg dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .Ain    (Ain),
        .Bin    (Bin),
        .ALUCtl (ALUCtl),
        .carryIn(carryIn),
        .ALUOut (ALUOut),
        .status (status)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic r, logic [4:0] ctl, logic cin,
                                logic [63:0] a, logic [63:0] b,
                                logic [63:0] eo, logic [3:0] es);
        vec_t v;
        v.name = name; v.rst_n = r; v.ctl = ctl; v.cin = cin;
        v.a = a; v.b = b; v.exp_out = eo; v.exp_st = es;
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst_n   = v.rst_n;
        ALUCtl  = v.ctl;
        carryIn = v.cin;
        Ain     = v.a;
        Bin     = v.b;
    endtask

    initial begin
        // Reset held for two edges with a busy add on the inputs.
        drive(mk("rst", 1'b0, 5'b01000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h0));
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("reset_out", ALUOut, 64'h0);
            check("reset_status", 64'(status), 64'h0);
        end

        vecs.push_back(mk("and",        1, 5'b00000, 0, 64'd6, 64'd3, 64'd2, 4'b0000));
        vecs.push_back(mk("or_notb",    1, 5'b00101, 0, 64'd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 4'b0010));
        vecs.push_back(mk("xor",        1, 5'b01100, 0, 64'd3, 64'd6, 64'd5, 4'b0000));
        vecs.push_back(mk("nand_inv",   1, 5'b00011, 0, 64'd6, 64'd3, 64'hFFFF_FFFF_FFFF_FFF8, 4'b0010));
        vecs.push_back(mk("and_notb",   1, 5'b00001, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010));
        vecs.push_back(mk("add_cin",    1, 5'b01000, 1, 64'd2, 64'd3, 64'd6, 4'b0000));
        vecs.push_back(mk("sub_eq",     1, 5'b01001, 1, 64'd5, 64'd5, 64'd0, 4'b0101));
        vecs.push_back(mk("sub_borrow", 1, 5'b01001, 1, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0010));
        vecs.push_back(mk("add_povf",   1, 5'b01000, 0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1010));
        vecs.push_back(mk("add_nvf",    1, 5'b01000, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 4'b1101));
        vecs.push_back(mk("add_cout",   1, 5'b01000, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h0, 4'b0101));
        vecs.push_back(mk("lsl",        1, 5'b10000, 1, 64'd1, 64'd2, 64'd4, 4'b0000));
        vecs.push_back(mk("lsr",        1, 5'b10100, 1, 64'd2, 64'd1, 64'd1, 4'b0000));
        vecs.push_back(mk("lsl_hib",    1, 5'b10000, 0, 64'd1, 64'h43, 64'd8, 4'b0000));
        vecs.push_back(mk("lsl_63",     1, 5'b10000, 0, 64'd1, 64'd63, 64'h8000_0000_0000_0000, 4'b0010));
        vecs.push_back(mk("lsr_63",     1, 5'b10100, 0, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 4'b0000));
        vecs.push_back(mk("lsl_0",      1, 5'b10000, 0, 64'h1234_5678_9ABC_DEF0, 64'h40, 64'h1234_5678_9ABC_DEF0, 4'b0000));
        vecs.push_back(mk("lsl_inv_ign",1, 5'b10011, 0, 64'd1, 64'd4, 64'd16, 4'b0000));
        vecs.push_back(mk("op110",      1, 5'b11000, 1, 64'd5, 64'd3, 64'd0, 4'b0001));
        vecs.push_back(mk("op111",      1, 5'b11111, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0, 4'b0001));
        vecs.push_back(mk("rst_mid",    0, 5'b00001, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'd0, 4'b0000));
        vecs.push_back(mk("after_rst",  1, 5'b00001, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010));

        // Each vector is loaded on one edge; between edges the next vector's
        // inputs must not disturb the registered result.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk); #1;
            check({vecs[i].name, "_out"}, ALUOut, vecs[i].exp_out);
            check({vecs[i].name, "_status"}, 64'(status), 64'(vecs[i].exp_st));
            if (i + 1 < vecs.size()) begin
                drive(vecs[i + 1]);
                #2;
                check({vecs[i].name, "_hold_out"}, ALUOut, vecs[i].exp_out);
                check({vecs[i].name, "_hold_status"}, 64'(status), 64'(vecs[i].exp_st));
            end
        end

        // Back-to-back sub then add: output after the add edge must show the add.
        drive(mk("s1", 1, 5'b01001, 1, 64'd10, 64'd4, 64'd0, 4'b0));
        @(posedge clk); #1;
        drive(mk("s2", 1, 5'b01000, 0, 64'd10, 64'd4, 64'd0, 4'b0));
        #1;
        check("stream_sub_out", ALUOut, 64'd6);
        check("stream_sub_status", 64'(status), 64'(4'b0100));
        @(posedge clk); #1;
        check("stream_add_out", ALUOut, 64'd14);
        check("stream_add_status", 64'(status), 64'(4'b0000));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
